pipeline_ctrl: RTL and testbench

// - Central sequencer for the 5-stage pipe (fetch/dec/exe/mem/wb).
// - Consumes hazard_module load_to_use_hazard, exe branch resolution, I/D-cache miss handshakes and mem-stage exceptions.
// - Emits per-stage stall/kill and PC-redirect select. Cycle-accurate owner of all freeze/flush decisions.

---
 rtl/pipeline_ctrl_pkg.sv | 97 +++++++++
 rtl/pipeline_ctrl_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, defaults and output-bundle helpers for the pipe sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned TRAP_CYCLES_DEF  = 2;
  localparam int unsigned MISS_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF        = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DMISS = 2'd1,
    ST_IMISS = 2'd2,
    ST_TRAP  = 2'd3
  } pipe_ctrl_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_TRAP   = 2'd2
  } redirect_sel_e;

  // Per-stage freeze/flush bundle driven every cycle
  typedef struct packed {
    logic          stall_fetch;
    logic          stall_dec;
    logic          stall_exe;
    logic          stall_mem;
    logic          kill_fetch;
    logic          kill_dec;
    logic          kill_exe;
    logic          kill_mem;
    logic          kill_wb;
    redirect_sel_e redirect_sel;
  } pipe_ctrl_t;

  // Quiet pipe: nothing held, nothing flushed
  function automatic pipe_ctrl_t ctrl_none();
    pipe_ctrl_t c;
    c.stall_fetch  = 1'b0;
    c.stall_dec    = 1'b0;
    c.stall_exe    = 1'b0;
    c.stall_mem    = 1'b0;
    c.kill_fetch   = 1'b0;
    c.kill_dec     = 1'b0;
    c.kill_exe     = 1'b0;
    c.kill_mem     = 1'b0;
    c.kill_wb      = 1'b0;
    c.redirect_sel = REDIR_NONE;
    return c;
  endfunction

  // D-miss: freeze everything up to mem, bubble into wb
  function automatic pipe_ctrl_t ctrl_dmiss();
    pipe_ctrl_t c;
    c             = ctrl_none();
    c.stall_fetch = 1'b1;
    c.stall_dec   = 1'b1;
    c.stall_exe   = 1'b1;
    c.stall_mem   = 1'b1;
    c.kill_wb     = 1'b1;
    return c;
  endfunction

  // I-miss: hold fetch, feed bubbles into dec
  function automatic pipe_ctrl_t ctrl_imiss();
    pipe_ctrl_t c;
    c            = ctrl_none();
    c.stall_fetch = 1'b1;
    c.kill_dec    = 1'b1;
    return c;
  endfunction

  // Back-end event decode shared by RUN and IMISS (priority exc > dmiss > branch > ltu)
  function automatic pipe_ctrl_t back_end_ctrl(input logic exc, input logic dmiss,
                                               input logic br, input logic ltu);
    pipe_ctrl_t c;
    c = ctrl_none();
    if (exc) begin
      c.kill_fetch   = 1'b1;
      c.kill_dec     = 1'b1;
      c.kill_exe     = 1'b1;
      c.kill_mem     = 1'b1;
      c.redirect_sel = REDIR_TRAP;
    end else if (dmiss) begin
      c = ctrl_dmiss();
    end else if (br) begin
      c.kill_fetch   = 1'b1;
      c.kill_dec     = 1'b1;
      c.redirect_sel = REDIR_BRANCH;
    end else if (ltu) begin
      c.stall_fetch = 1'b1;
      c.stall_dec   = 1'b1;
      c.kill_exe    = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_counter.sv
// Shared cycle counter: load, saturating increment, floor-at-zero decrement.
module pipeline_ctrl_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_VAL = MISS_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // Load wins, then increment (saturating at MAX_VAL), then decrement (stops at 0)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != CNT_W'(MAX_VAL))) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central freeze/flush sequencer for the fetch/dec/exe/mem/wb pipe.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_CYCLES  = TRAP_CYCLES_DEF,
  parameter int unsigned MISS_TIMEOUT = MISS_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_to_use_hazard,
  input  logic       branch_taken,
  input  logic       exc_valid,
  input  logic       dcache_miss,
  input  logic       dcache_fill_done,
  input  logic       icache_miss,
  input  logic       icache_fill_done,
  output logic       stall_fetch,
  output logic       stall_dec,
  output logic       stall_exe,
  output logic       stall_mem,
  output logic       kill_fetch,
  output logic       kill_dec,
  output logic       kill_exe,
  output logic       kill_mem,
  output logic       kill_wb,
  output logic [1:0] redirect_sel,
  output logic       miss_timeout
);

  pipe_ctrl_state_e state_q, state_d;
  logic             drop_fill_q, drop_fill_d;
  pipe_ctrl_t       ctrl, back_ctrl;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             in_miss;

  // State and pending-fill-drop registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      drop_fill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_fill_q <= drop_fill_d;
    end
  end

  // Next-state and per-stage control decode
  always_comb begin
    state_d     = state_q;
    drop_fill_d = drop_fill_q;
    ctrl        = ctrl_none();
    back_ctrl   = back_end_ctrl(exc_valid, dcache_miss, branch_taken, load_to_use_hazard);
    case (state_q)
      ST_RUN: begin
        ctrl = back_ctrl;
        if (exc_valid) begin
          state_d = ST_TRAP;
        end else if (dcache_miss) begin
          state_d = ST_DMISS;
        end else if (!branch_taken && !load_to_use_hazard && icache_miss) begin
          ctrl    = ctrl_imiss();
          state_d = ST_IMISS;
        end
      end
      ST_DMISS: begin
        // Trap and fetch events wait until the mem inst completes
        if (dcache_fill_done) begin
          state_d = ST_RUN;
        end else begin
          ctrl = ctrl_dmiss();
        end
      end
      ST_IMISS: begin
        if (exc_valid) begin
          ctrl    = back_ctrl;
          state_d = ST_TRAP;
        end else if (dcache_miss) begin
          ctrl    = back_ctrl;
          state_d = ST_DMISS;
        end else if (icache_fill_done) begin
          // A branch resolved during the miss makes the refilled inst stale
          ctrl            = back_ctrl;
          ctrl.kill_fetch = back_ctrl.kill_fetch | drop_fill_q;
          drop_fill_d     = 1'b0;
          state_d         = ST_RUN;
        end else begin
          ctrl = ctrl_imiss();
          if (branch_taken) begin
            ctrl.redirect_sel = REDIR_BRANCH;
            drop_fill_d       = 1'b1;
          end else if (load_to_use_hazard) begin
            ctrl.kill_exe = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        ctrl.kill_fetch = 1'b1;
        if (cnt == '0) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Outputs stay quiet while reset is held, whatever the inputs do
    if (!rst) begin
      ctrl = ctrl_none();
    end
  end

  // Counter restarts on every state change; trap entry preloads the settle count
  always_comb begin
    in_miss      = (state_q == ST_DMISS) || (state_q == ST_IMISS);
    cnt_load     = (state_d != state_q);
    cnt_load_val = (state_d == ST_TRAP) ? CNT_W'(TRAP_CYCLES - 1) : '0;
  end

  pipeline_ctrl_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (MISS_TIMEOUT)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (in_miss),
    .dec      (state_q == ST_TRAP),
    .cnt      (cnt)
  );

  // Sticky timeout; the cycle that raised the miss counts as its first miss cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_timeout <= 1'b0;
    end else if (in_miss && ((32'(cnt) + 32'd2) >= MISS_TIMEOUT)) begin
      miss_timeout <= 1'b1;
    end
  end

  // Drive the bundle onto the stage ports
  always_comb begin
    stall_fetch  = ctrl.stall_fetch;
    stall_dec    = ctrl.stall_dec;
    stall_exe    = ctrl.stall_exe;
    stall_mem    = ctrl.stall_mem;
    kill_fetch   = ctrl.kill_fetch;
    kill_dec     = ctrl.kill_dec;
    kill_exe     = ctrl.kill_exe;
    kill_mem     = ctrl.kill_mem;
    kill_wb      = ctrl.kill_wb;
    redirect_sel = 2'(ctrl.redirect_sel);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_to_use_hazard = 1'b0;
  logic branch_taken = 1'b0;
  logic exc_valid = 1'b0;
  logic dcache_miss = 1'b0;
  logic dcache_fill_done = 1'b0;
  logic icache_miss = 1'b0;
  logic icache_fill_done = 1'b0;
  logic stall_fetch, stall_dec, stall_exe, stall_mem;
  logic kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb;
  logic [1:0] redirect_sel;
  logic miss_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .TRAP_CYCLES  (2),
    .MISS_TIMEOUT (4),
    .CNT_W        (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load_to_use_hazard (load_to_use_hazard),
    .branch_taken       (branch_taken),
    .exc_valid          (exc_valid),
    .dcache_miss        (dcache_miss),
    .dcache_fill_done   (dcache_fill_done),
    .icache_miss        (icache_miss),
    .icache_fill_done   (icache_fill_done),
    .stall_fetch        (stall_fetch),
    .stall_dec          (stall_dec),
    .stall_exe          (stall_exe),
    .stall_mem          (stall_mem),
    .kill_fetch         (kill_fetch),
    .kill_dec           (kill_dec),
    .kill_exe           (kill_exe),
    .kill_mem           (kill_mem),
    .kill_wb            (kill_wb),
    .redirect_sel       (redirect_sel),
    .miss_timeout       (miss_timeout)
  );

  // {sf,sd,se,sm, kf,kd,ke,km,kw, redirect_sel}
  logic [10:0] outs;
  assign outs = {stall_fetch, stall_dec, stall_exe, stall_mem,
                 kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb, redirect_sel};

  localparam logic [10:0] O_NONE   = 11'b0000_00000_00;
  localparam logic [10:0] O_EXC    = 11'b0000_11110_10;
  localparam logic [10:0] O_DMISS  = 11'b1111_00001_00;
  localparam logic [10:0] O_BR     = 11'b0000_11000_01;
  localparam logic [10:0] O_LTU    = 11'b1100_00100_00;
  localparam logic [10:0] O_IMISS  = 11'b1000_01000_00;
  localparam logic [10:0] O_TRAP   = 11'b0000_10000_00;
  localparam logic [10:0] O_IM_LTU = 11'b1000_01100_00;
  localparam logic [10:0] O_IM_BR  = 11'b1000_01000_01;

  // in = {exc, dmiss, br, ltu, imiss, dfill, ifill}
  typedef struct {
    string       name;
    logic [6:0]  in;
    logic [10:0] exp_now;
    logic [10:0] exp_next;
  } vec_t;

  task automatic drive(input logic [6:0] in);
    {exc_valid, dcache_miss, branch_taken, load_to_use_hazard,
     icache_miss, dcache_fill_done, icache_fill_done} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [10:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: outs=%b required=%b", name, outs, exp);
    end
  endtask

  task automatic check_mt(input string name, input logic exp);
    n_cmp++;
    if (miss_timeout !== exp) begin
      n_bad++;
      $display("FAIL %s: miss_timeout=%b required=%b", name, miss_timeout, exp);
    end
  endtask

  // Drive inputs at posedge+1, check at the following negedge, then advance
  task automatic step(input string name, input logic [6:0] in, input logic [10:0] exp);
    drive(in);
    #4;
    check_outs(name, exp);
    tick();
  endtask

  task automatic apply_reset();
    drive(7'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"idle",          7'b0000000, O_NONE,  O_NONE};
    vecs[1]  = '{"ltu",           7'b0001000, O_LTU,   O_NONE};
    vecs[2]  = '{"branch",        7'b0010000, O_BR,    O_NONE};
    vecs[3]  = '{"branch_ltu",    7'b0011000, O_BR,    O_NONE};
    vecs[4]  = '{"exc",           7'b1000000, O_EXC,   O_TRAP};
    vecs[5]  = '{"exc_dmiss_br",  7'b1110000, O_EXC,   O_TRAP};
    vecs[6]  = '{"dmiss",         7'b0100000, O_DMISS, O_DMISS};
    vecs[7]  = '{"dmiss_br_ltu",  7'b0111000, O_DMISS, O_DMISS};
    vecs[8]  = '{"imiss",         7'b0000100, O_IMISS, O_IMISS};
    vecs[9]  = '{"imiss_ltu",     7'b0001100, O_LTU,   O_NONE};
    vecs[10] = '{"imiss_br",      7'b0010100, O_BR,    O_NONE};
    vecs[11] = '{"stray_fills",   7'b0000011, O_NONE,  O_NONE};
    vecs[12] = '{"imiss_dmiss",   7'b0100100, O_DMISS, O_DMISS};

    // Power-on reset; outputs must stay quiet even with a hazard present
    #1 rst = 1'b0;
    load_to_use_hazard = 1'b1;
    #2;
    check_outs("reset_outs", O_NONE);
    check_mt("reset_mt", 1'b0);
    tick();
    load_to_use_hazard = 1'b0;
    rst = 1'b1;

    // Single-cycle decode from RUN, then the following idle cycle shows the state taken
    for (int i = 0; i < 13; i++) begin
      apply_reset();
      step({vecs[i].name, "_now"}, vecs[i].in, vecs[i].exp_now);
      step({vecs[i].name, "_next"}, 7'b0, vecs[i].exp_next);
    end

    // D-miss t0..t0+4 with fill at t0+5; exc and stray I-fill inside are ignored
    apply_reset();
    step("dm_t0", 7'b0100000, O_DMISS);
    step("dm_t1", 7'b0100000, O_DMISS);
    step("dm_t2_exc", 7'b1100000, O_DMISS);
    drive(7'b0100001);
    #4;
    check_outs("dm_t3_ifill", O_DMISS);
    check_mt("dm_t3_mt", 1'b0);
    tick();
    drive(7'b0100000);
    #4;
    check_outs("dm_t4", O_DMISS);
    check_mt("dm_t4_mt", 1'b1);
    tick();
    step("dm_t5_fill", 7'b0000010, O_NONE);
    step("dm_t6_run_ltu", 7'b0001000, O_LTU);

    // I-miss with ltu, then branch during the miss; refill must be killed
    apply_reset();
    step("im_t0", 7'b0000100, O_IMISS);
    step("im_t1_ltu", 7'b0001100, O_IM_LTU);
    step("im_t2_br", 7'b0010100, O_IM_BR);
    step("im_t3", 7'b0000100, O_IMISS);
    step("im_t4_fill", 7'b0000001, O_TRAP);
    step("im_t5_run", 7'b0000000, O_NONE);

    // I-miss refill with no branch outstanding passes through untouched
    apply_reset();
    step("im2_t0", 7'b0000100, O_IMISS);
    step("im2_t1_fill", 7'b0000001, O_NONE);
    step("im2_t2_run", 7'b0000000, O_NONE);

    // Trap entry, a repeated exc is ignored, two settle cycles, back to RUN
    apply_reset();
    step("trap_t0", 7'b1000000, O_EXC);
    step("trap_t1_exc", 7'b1000000, O_TRAP);
    step("trap_t2", 7'b0000000, O_TRAP);
    step("trap_t3_run_ltu", 7'b0001000, O_LTU);

    // Held D-miss without fill: sticky timeout, then async reset mid-miss
    apply_reset();
    step("to_t0", 7'b0100000, O_DMISS);
    for (int k = 1; k < 10; k++) begin
      drive(7'b0100000);
      #4;
      check_mt($sformatf("to_t%0d_mt", k), (k >= 4) ? 1'b1 : 1'b0);
      tick();
    end
    check_outs("to_t10_pre_rst", O_DMISS);
    rst = 1'b0;
    #1;
    check_outs("to_rst_outs", O_NONE);
    check_mt("to_rst_mt", 1'b0);
    tick();
    rst = 1'b1;
    step("to_after_rst", 7'b0000000, O_NONE);
    check_mt("to_after_rst_mt", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
